// File: rtl/traffic_phase_ctrl.sv
// Two-way intersection phase controller with a pedestrian walk served during all-red
// clearance and a fault-driven red blink mode. All outputs come straight from flops.
module traffic_phase_ctrl #(
    parameter int GREEN_S     = 10,
    parameter int YELLOW_S    = 3,
    parameter int ALLRED_S    = 1,
    parameter int WALK_S      = 5,
    parameter int SHORT_GREEN = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1hz,
    input  logic       tick_2hz,
    input  logic       fault,
    input  logic       ped_req,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic       ped_walk,
    output logic [7:0] countdown,
    output logic [2:0] dbg_state
);

    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        ALL_RED_1 = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        ALL_RED_2 = 3'd5,
        ERROR     = 3'd6
    } state_t;

    localparam logic [7:0] GREEN_CD  = 8'(GREEN_S);
    localparam logic [7:0] YELLOW_CD = 8'(YELLOW_S);
    localparam logic [7:0] ALLRED_CD = 8'(ALLRED_S);
    localparam logic [7:0] WALK_CD   = 8'(WALK_S);
    localparam logic [7:0] SHORT_CD  = 8'(SHORT_GREEN);

    localparam logic [2:0] LAMP_R = 3'b100;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_G = 3'b001;

    state_t     state, state_nxt;
    logic [7:0] cd_nxt;
    logic       ped_pending, pend_nxt;
    logic       blink, blink_nxt;
    logic       walk_nxt;
    logic [2:0] ns_nxt, ew_nxt;
    logic       in_green;

    assign dbg_state = state;
    assign in_green  = (state == NS_GREEN) || (state == EW_GREEN);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ALL_RED_2;
            countdown   <= ALLRED_CD;
            ped_pending <= 1'b0;
            blink       <= 1'b0;
            ped_walk    <= 1'b0;
            ns_light    <= LAMP_R;
            ew_light    <= LAMP_R;
        end else begin
            state       <= state_nxt;
            countdown   <= cd_nxt;
            ped_pending <= pend_nxt;
            blink       <= blink_nxt;
            ped_walk    <= walk_nxt;
            ns_light    <= ns_nxt;
            ew_light    <= ew_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cd_nxt    = countdown;
        pend_nxt  = ped_pending;
        blink_nxt = blink;
        walk_nxt  = ped_walk;

        if (fault) begin
            state_nxt = ERROR;
            cd_nxt    = 8'd0;
            pend_nxt  = 1'b0;
            walk_nxt  = 1'b0;
            blink_nxt = (state == ERROR) ? (blink ^ tick_2hz) : 1'b1;
        end else if (state == ERROR) begin
            cd_nxt   = 8'd0;
            pend_nxt = 1'b0;
            walk_nxt = 1'b0;
            if (tick_1hz) begin
                state_nxt = ALL_RED_2;
                cd_nxt    = ALLRED_CD;
                blink_nxt = 1'b0;
            end else begin
                blink_nxt = blink ^ tick_2hz;
            end
        end else begin
            pend_nxt = ped_pending | ped_req;
            if (tick_1hz && countdown == 8'd1) begin
                walk_nxt = 1'b0;
                case (state)
                    NS_GREEN:  begin state_nxt = NS_YELLOW; cd_nxt = YELLOW_CD; end
                    NS_YELLOW: state_nxt = ALL_RED_1;
                    ALL_RED_1: begin state_nxt = EW_GREEN;  cd_nxt = GREEN_CD;  end
                    EW_GREEN:  begin state_nxt = EW_YELLOW; cd_nxt = YELLOW_CD; end
                    EW_YELLOW: state_nxt = ALL_RED_2;
                    default:   begin state_nxt = NS_GREEN;  cd_nxt = GREEN_CD;  end
                endcase
                // Only an already-latched request is served; a same-cycle request waits.
                if (state_nxt == ALL_RED_1 || state_nxt == ALL_RED_2) begin
                    if (ped_pending) begin
                        cd_nxt   = WALK_CD;
                        walk_nxt = 1'b1;
                        pend_nxt = ped_req;
                    end else begin
                        cd_nxt = ALLRED_CD;
                    end
                end
            end else if (in_green && (ped_pending || ped_req) && countdown > SHORT_CD) begin
                cd_nxt = SHORT_CD;
            end else if (tick_1hz) begin
                cd_nxt = countdown - 8'd1;
            end
        end
    end

    always_comb begin
        ns_nxt = LAMP_R;
        ew_nxt = LAMP_R;
        case (state_nxt)
            NS_GREEN:  ns_nxt = LAMP_G;
            NS_YELLOW: ns_nxt = LAMP_Y;
            EW_GREEN:  ew_nxt = LAMP_G;
            EW_YELLOW: ew_nxt = LAMP_Y;
            ERROR: begin
                ns_nxt = {blink_nxt, 2'b00};
                ew_nxt = {blink_nxt, 2'b00};
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Bench for traffic_phase_ctrl: a cycle-by-cycle vector table for the normal phase
// cycle and pedestrian handling, then hand-written fault and reset sequences.
module tb_traffic_phase_ctrl;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;
    localparam logic [2:0] O = 3'b000;

    typedef struct {
        logic       rst_n;
        logic       t1;
        logic       t2;
        logic       f;
        logic       p;
        logic [2:0] ns;
        logic [2:0] ew;
        logic       walk;
        logic [7:0] cd;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick_1hz = 1'b0;
    logic       tick_2hz = 1'b0;
    logic       fault = 1'b0;
    logic       ped_req = 1'b0;
    logic [2:0] ns_light, ew_light, dbg_state;
    logic       ped_walk;
    logic [7:0] countdown;

    int checks = 0;
    int failures = 0;
    vec_t vecs[$];

    traffic_phase_ctrl #(
        .GREEN_S(5), .YELLOW_S(2), .ALLRED_S(1), .WALK_S(4), .SHORT_GREEN(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz), .tick_2hz(tick_2hz),
        .fault(fault), .ped_req(ped_req), .ns_light(ns_light), .ew_light(ew_light),
        .ped_walk(ped_walk), .countdown(countdown), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    function automatic void add(input logic r, t1, t2, f, p,
                                input logic [2:0] ns, ew, input logic w, input logic [7:0] cd);
        vec_t v;
        v.rst_n = r; v.t1 = t1; v.t2 = t2; v.f = f; v.p = p;
        v.ns = ns; v.ew = ew; v.walk = w; v.cd = cd;
        vecs.push_back(v);
    endfunction

    // Tick-only rows counting down from n to 1 in a fixed lamp state.
    function automatic void run(input logic [2:0] ns, ew, input logic w, input int n);
        for (int c = n; c >= 1; c--) add(1, 1, 0, 0, 0, ns, ew, w, 8'(c));
    endfunction

    task automatic step(input logic r, t1, t2, f, p);
        @(negedge clk);
        rst_n = r; tick_1hz = t1; tick_2hz = t2; fault = f; ped_req = p;
        @(posedge clk);
        #1;
    endtask

    task automatic tk();
        step(1, 1, 0, 0, 0);
    endtask

    task automatic expect_out(input string name, input logic [2:0] ns, ew,
                              input logic w, input logic [7:0] cd);
        checks++;
        if (ns_light !== ns || ew_light !== ew || ped_walk !== w || countdown !== cd) begin
            failures++;
            $display("FAIL %s: got ns=%b ew=%b walk=%b cd=%0d, want ns=%b ew=%b walk=%b cd=%0d",
                     name, ns_light, ew_light, ped_walk, countdown, ns, ew, w, cd);
        end
    endtask

    initial begin
        // Reset and one full 16-tick cycle.
        add(0, 0, 0, 0, 0, R, R, 0, 1);
        add(1, 0, 0, 0, 0, R, R, 0, 1);
        add(1, 1, 0, 0, 0, G, R, 0, 5);
        run(G, R, 0, 4);
        add(1, 1, 0, 0, 0, Y, R, 0, 2);
        add(1, 0, 1, 0, 0, Y, R, 0, 2);
        add(1, 1, 0, 0, 0, Y, R, 0, 1);
        add(1, 1, 0, 0, 0, R, R, 0, 1);
        add(1, 1, 0, 0, 0, R, G, 0, 5);
        run(R, G, 0, 4);
        add(1, 1, 0, 0, 0, R, Y, 0, 2);
        add(1, 1, 0, 0, 0, R, Y, 0, 1);
        add(1, 1, 0, 0, 0, R, R, 0, 1);
        add(1, 1, 0, 0, 0, G, R, 0, 5);
        // Request at full green truncates to 2, then walk in ALL_RED_1.
        add(1, 0, 0, 0, 1, G, R, 0, 2);
        add(1, 0, 1, 0, 0, G, R, 0, 2);
        add(1, 1, 0, 0, 0, G, R, 0, 1);
        add(1, 1, 0, 0, 0, Y, R, 0, 2);
        add(1, 1, 0, 0, 0, Y, R, 0, 1);
        add(1, 1, 0, 0, 0, R, R, 1, 4);
        run(R, R, 1, 3);
        add(1, 1, 0, 0, 0, R, G, 0, 5);
        // Request coincident with ALL_RED_2 entry is not served there.
        run(R, G, 0, 4);
        add(1, 1, 0, 0, 0, R, Y, 0, 2);
        add(1, 1, 0, 0, 0, R, Y, 0, 1);
        add(1, 1, 0, 0, 1, R, R, 0, 1);
        add(1, 1, 0, 0, 0, G, R, 0, 5);
        add(1, 0, 0, 0, 0, G, R, 0, 2);
        add(1, 1, 0, 0, 0, G, R, 0, 1);
        add(1, 1, 0, 0, 0, Y, R, 0, 2);
        add(1, 1, 0, 0, 0, Y, R, 0, 1);
        add(1, 1, 0, 0, 0, R, R, 1, 4);
        run(R, R, 1, 3);
        add(1, 1, 0, 0, 0, R, G, 0, 5);
        // Request at green countdown=1: no truncation, walk after yellow.
        run(R, G, 0, 4);
        add(1, 1, 0, 0, 0, R, Y, 0, 2);
        add(1, 1, 0, 0, 0, R, Y, 0, 1);
        add(1, 1, 0, 0, 0, R, R, 0, 1);
        add(1, 1, 0, 0, 0, G, R, 0, 5);
        run(G, R, 0, 4);
        add(1, 0, 0, 0, 1, G, R, 0, 1);
        add(1, 1, 0, 0, 0, Y, R, 0, 2);
        add(1, 1, 0, 0, 0, Y, R, 0, 1);
        add(1, 1, 0, 0, 0, R, R, 1, 4);
        run(R, R, 1, 3);
        add(1, 1, 0, 0, 0, R, G, 0, 5);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst_n, vecs[i].t1, vecs[i].t2, vecs[i].f, vecs[i].p);
            expect_out($sformatf("vec[%0d]", i), vecs[i].ns, vecs[i].ew, vecs[i].walk, vecs[i].cd);
        end

        // Fault coincident with the phase-ending tick wins; blink on tick_2hz.
        for (int i = 0; i < 4; i++) tk();
        expect_out("ew_green_cd1", R, G, 0, 1);
        step(1, 1, 0, 1, 1);
        expect_out("fault_entry", R, R, 0, 0);
        step(1, 0, 1, 1, 0);
        expect_out("blink_off", O, O, 0, 0);
        step(1, 0, 1, 1, 0);
        expect_out("blink_on", R, R, 0, 0);
        step(1, 1, 0, 1, 0);
        expect_out("fault_holds_on_tick", R, R, 0, 0);
        step(1, 0, 0, 0, 1);
        expect_out("err_ped_ignored", R, R, 0, 0);
        step(1, 0, 1, 0, 0);
        expect_out("err_blink_no_fault", O, O, 0, 0);
        step(1, 1, 0, 0, 0);
        expect_out("err_exit_all_red_2", R, R, 0, 1);
        tk();
        expect_out("err_exit_ns_green", G, R, 0, 5);
        step(1, 0, 0, 0, 0);
        expect_out("no_trunc_after_err", G, R, 0, 5);
        for (int i = 0; i < 4; i++) tk();
        tk(); tk(); tk();
        expect_out("no_walk_after_err", R, R, 0, 1);

        // Reset mid EW_GREEN, with fault and tick also asserted.
        tk(); tk(); tk();
        expect_out("ew_green_cd3", R, G, 0, 3);
        step(0, 1, 0, 1, 1);
        expect_out("reset_mid_phase", R, R, 0, 1);
        step(1, 0, 0, 0, 0);
        expect_out("reset_release_idle", R, R, 0, 1);
        tk();
        expect_out("reset_then_ns_green", G, R, 0, 5);
        step(1, 0, 0, 0, 0);
        expect_out("reset_clears_pending", G, R, 0, 5);

        // Reset during a walk drops ped_walk and the request.
        step(1, 0, 0, 0, 1);
        expect_out("trunc_again", G, R, 0, 2);
        tk(); tk(); tk(); tk();
        expect_out("walk_before_reset", R, R, 1, 4);
        step(0, 0, 0, 0, 0);
        expect_out("reset_in_walk", R, R, 0, 1);
        tk();
        step(1, 0, 0, 0, 0);
        expect_out("walk_reset_no_pending", G, R, 0, 5);

        // Reset while in ERROR with fault still high.
        step(1, 0, 0, 1, 0);
        expect_out("err_again", R, R, 0, 0);
        step(0, 0, 0, 1, 0);
        expect_out("reset_in_error", R, R, 0, 1);
        step(1, 1, 0, 0, 0);
        expect_out("err_reset_ns_green", G, R, 0, 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
